// File: rtl/sec_b2a_if.sv
// sec_b2a streaming port bundle.
// Carries valid, enable, fresh randomness and the share buses.
interface sec_b2a_if #(
  parameter int K_WIDTH  = 32,
  parameter int N_SHARES = 3
);
  localparam int K = K_WIDTH;
  localparam int N = N_SHARES;
  localparam int M = N * (N - 1);
  localparam int LOG_K = $clog2(N + 1) - 1;
  localparam int R_INIT = N - 1;
  localparam int R_CSA = (N - 2) * M;
  localparam int R_KSA = 2 * $clog2(K - 1) * M;
  localparam int R_FXOR =
    LOG_K * (2 ** (LOG_K - 1)) + N - 2 ** LOG_K;
  localparam int RANDNUM =
    R_INIT + R_CSA + 2 * R_KSA + R_FXOR;

  logic                   dvld;
  logic                   ena;
  logic [RANDNUM*K-1:0]   rnd;
  logic [N*K-1:0]         i_b;
  logic [N*K-1:0]         o_a;
  logic                   ovld;

  modport master (
    output dvld, ena, rnd, i_b,
    input  o_a, ovld
  );

  modport slave (
    input  dvld, ena, rnd, i_b,
    output o_a, ovld
  );
endinterface

// File: rtl/sec_b2a.sv
// Masked Boolean-to-arithmetic converter.
// CSA tree + two masked Kogge-Stone adders, fixed latency.
module sec_b2a #(
  parameter int K_WIDTH  = 32,
  parameter int N_SHARES = 3
) (
  input  logic      clk,
  input  logic      rst_n,
  sec_b2a_if.slave  bus
);

  function automatic int csa_cnt(int n, int l);
    int c;
    c = n;
    for (int i = 0; i < l; i++) c = c - c / 3;
    return c;
  endfunction

  function automatic int csa_off(int n, int l);
    int c;
    int o;
    c = n;
    o = 0;
    for (int i = 0; i < l; i++) begin
      o = o + c / 3;
      c = c - c / 3;
    end
    return o;
  endfunction

  function automatic int csa_layers(int n);
    int c;
    int d;
    c = n;
    d = 0;
    while (c > 2) begin
      c = c - c / 3;
      d = d + 1;
    end
    return d;
  endfunction

  localparam int K = K_WIDTH;
  localparam int N = N_SHARES;
  localparam int M = N * (N - 1);
  localparam int KL = $clog2(K - 1);
  localparam int LOG_K = $clog2(N + 1) - 1;
  localparam int R_INIT = N - 1;
  localparam int R_CSA = (N - 2) * M;
  localparam int R_KSA = 2 * KL * M;
  localparam int R_FXOR =
    LOG_K * (2 ** (LOG_K - 1)) + N - 2 ** LOG_K;
  localparam int RANDNUM =
    R_INIT + R_CSA + 2 * R_KSA + R_FXOR;
  localparam int OFF_CSA = R_INIT;
  localparam int OFF_K1 = OFF_CSA + R_CSA;
  localparam int OFF_FX = OFF_K1 + 2 * R_KSA;
  localparam int DCSA = csa_layers(N);
  localparam int DKSA = KL + 1;
  localparam int DX = DCSA + DKSA;
  localparam int LAT = DCSA + 2 * DKSA;

  typedef logic [K-1:0]          w_t;
  typedef logic [N-1:0][K-1:0]   sh_t;
  typedef logic [M-1:0][K-1:0]   rm_t;
  typedef logic [N-2:0][K-1:0]   rv_t;

  // ISW-style AND with a second random set refreshing the result.
  function automatic sh_t sec_and(sh_t a, sh_t b, rm_t r);
    sh_t c;
    int  p;
    for (int i = 0; i < N; i++) c[i] = a[i] & b[i];
    p = 0;
    for (int i = 0; i < N; i++) begin
      for (int j = i + 1; j < N; j++) begin
        c[i] = c[i] ^ (a[i] & b[j]) ^ r[p] ^ r[M/2+p];
        c[j] = c[j] ^ (a[j] & b[i]) ^ r[p] ^ r[M/2+p];
        p = p + 1;
      end
    end
    return c;
  endfunction

  function automatic sh_t shl(sh_t a, int s);
    sh_t o;
    for (int i = 0; i < N; i++) o[i] = a[i] << s;
    return o;
  endfunction

  logic [RANDNUM-1:0][K-1:0] rw;
  assign rw = bus.rnd;

  sh_t s0 [N];
  sh_t cs [DCSA+1][N];

  // Summands ~r_1..~r_{N-1} and N-1 sum to -(r_1+..+r_{N-1}).
  always_comb begin
    for (int s = 0; s < N; s++) s0[s] = '0;
    for (int s = 0; s < N - 1; s++) s0[s][s] = ~rw[s];
    s0[N-1][N-1] = w_t'(N - 1);
  end

  for (genvar k = 0; k < N; k++) begin : g_s0
    assign cs[0][k] = s0[k];
  end

  for (genvar l = 0; l < DCSA; l++) begin : g_csa
    localparam int C = csa_cnt(N, l);
    localparam int NC = C / 3;
    localparam int RB = OFF_CSA + csa_off(N, l) * M;
    sh_t d [N];
    sh_t q [N];

    always_comb begin
      for (int k = 0; k < N; k++) d[k] = '0;
      for (int j = 0; j < NC; j++) begin
        d[2*j] = cs[l][3*j] ^ cs[l][3*j+1]
               ^ cs[l][3*j+2];
        d[2*j+1] = shl(
          sec_and(cs[l][3*j] ^ cs[l][3*j+1],
                  cs[l][3*j+1] ^ cs[l][3*j+2],
                  rw[RB+j*M +: M])
          ^ cs[l][3*j+1], 1);
      end
      for (int j = 3 * NC; j < C; j++) d[j-NC] = cs[l][j];
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int k = 0; k < N; k++) q[k] <= '0;
      end else if (bus.ena) begin
        q <= d;
      end
    end

    for (genvar k = 0; k < N; k++) begin : g_o
      assign cs[l+1][k] = q[k];
    end
  end

  sh_t x_q [DX];
  rv_t r_q [LAT];
  logic [LAT-1:0] v_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DX; i++) x_q[i] <= '0;
      for (int i = 0; i < LAT; i++) r_q[i] <= '0;
      v_q <= '0;
    end else if (bus.ena) begin
      x_q[0] <= bus.i_b;
      for (int i = 1; i < DX; i++) x_q[i] <= x_q[i-1];
      r_q[0] <= rw[N-2:0];
      for (int i = 1; i < LAT; i++) r_q[i] <= r_q[i-1];
      v_q <= {v_q[LAT-2:0], bus.dvld};
    end
  end

  sh_t ka [2];
  sh_t kb [2];
  sh_t ks [2];

  assign ka[0] = cs[DCSA][0];
  assign kb[0] = cs[DCSA][1];
  assign ka[1] = x_q[DX-1];
  assign kb[1] = ks[0];

  for (genvar u = 0; u < 2; u++) begin : g_ksa
    localparam int RB = OFF_K1 + u * R_KSA;
    sh_t g_d [KL];
    sh_t p_d [KL];
    sh_t h_d [KL];
    sh_t g_q [KL];
    sh_t p_q [KL];
    sh_t h_q [KL];
    sh_t s_d;
    sh_t o_d;
    sh_t s_q;

    // h carries a^b down to the final sum-XOR.
    always_comb begin
      g_d[0] = sec_and(ka[u], kb[u], rw[RB +: M]);
      p_d[0] = ka[u] ^ kb[u];
      h_d[0] = ka[u] ^ kb[u];
      for (int t = 1; t < KL; t++) begin
        g_d[t] = g_q[t-1] ^ sec_and(
          p_q[t-1], shl(g_q[t-1], 1 << (t - 1)),
          rw[RB+(2*t-1)*M +: M]);
        p_d[t] = sec_and(
          p_q[t-1], shl(p_q[t-1], 1 << (t - 1)),
          rw[RB+2*t*M +: M]);
        h_d[t] = h_q[t-1];
      end
      s_d = h_q[KL-1] ^ shl(g_q[KL-1] ^ sec_and(
        p_q[KL-1], shl(g_q[KL-1], 1 << (KL - 1)),
        rw[RB+(2*KL-1)*M +: M]), 1);
    end

    if (u == 1) begin : g_fold
      sh_t f;
      w_t  z;
      always_comb begin
        f = s_d;
        for (int w = 0; w < R_FXOR; w++) begin
          f[w%N] = f[w%N] ^ rw[OFF_FX+w];
          f[(w+1)%N] = f[(w+1)%N] ^ rw[OFF_FX+w];
        end
        z = '0;
        for (int i = 0; i < N; i++) z = z ^ f[i];
        o_d = '0;
        o_d[N-1] = z;
      end
    end else begin : g_pass
      assign o_d = s_d;
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int t = 0; t < KL; t++) begin
          g_q[t] <= '0;
          p_q[t] <= '0;
          h_q[t] <= '0;
        end
        s_q <= '0;
      end else if (bus.ena) begin
        g_q <= g_d;
        p_q <= p_d;
        h_q <= h_d;
        s_q <= o_d;
      end
    end

    assign ks[u] = s_q;
  end

  assign bus.o_a = {ks[1][N-1], r_q[LAT-1]};
  assign bus.ovld = v_q[LAT-1];

endmodule

// File: tb/tb_sec_b2a.sv
// Randomized bench for sec_b2a (K=32, N=3).
// Reference: sum of outputs equals XOR of inputs L enabled cycles earlier.
module tb_sec_b2a;
  localparam int K = 32;
  localparam int N = 3;
  localparam int RN = 130;
  localparam int L = 13;

  logic clk = 1'b0;
  logic rst_n;

  sec_b2a_if #(.K_WIDTH(K), .N_SHARES(N)) bus ();

  sec_b2a #(.K_WIDTH(K), .N_SHARES(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit                    v;
    bit                    rz;
    logic [K-1:0]          sum;
    logic [N-2:0][K-1:0]   r;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int nvec = 0;
  int nerr = 0;

  task automatic chk(string tag, logic [K-1:0] got,
                     logic [K-1:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [N*K-1:0] rnd_ib();
    logic [N*K-1:0] r;
    for (int i = 0; i < N; i++) r[i*K +: K] = $urandom;
    return r;
  endfunction

  task automatic set_cur(bit v, bit rz);
    cur.v = v;
    cur.rz = rz;
    cur.sum = '0;
    cur.r = '0;
  endtask

  task automatic check();
    logic [K-1:0] s;
    chk("ovld", K'(bus.ovld), K'(cur.v));
    if (cur.rz)
      for (int i = 0; i < N; i++)
        chk("rst_oa", bus.o_a[i*K +: K], '0);
    if (cur.v) begin
      s = '0;
      for (int i = 0; i < N; i++) s += bus.o_a[i*K +: K];
      chk("sum", s, cur.sum);
      for (int i = 0; i < N - 1; i++)
        chk("r_share", bus.o_a[i*K +: K], cur.r[i]);
    end
  endtask

  // rmode: 0 random rnd, 1 all-zero rnd, 2 r words all ones
  task automatic apply(input logic [N*K-1:0] ib, input bit v,
                       input bit en, input int rmode);
    exp_t e;
    bus.i_b = ib;
    bus.dvld = v;
    bus.ena = en;
    for (int j = 0; j < RN; j++)
      bus.rnd[j*K +: K] = (rmode == 1) ? '0 : K'($urandom);
    if (rmode == 2)
      for (int j = 0; j < N - 1; j++) bus.rnd[j*K +: K] = '1;
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      set_cur(1'b0, 1'b1);
    end else if (en) begin
      e.v = v;
      e.rz = 1'b0;
      e.sum = '0;
      for (int i = 0; i < N; i++) e.sum ^= ib[i*K +: K];
      for (int i = 0; i < N - 1; i++)
        e.r[i] = bus.rnd[i*K +: K];
      q.push_back(e);
      if (q.size() == L) cur = q.pop_front();
      else set_cur(1'b0, 1'b0);
    end
    #1;
    check();
  endtask

  initial begin
    logic [K-1:0] w;
    rst_n = 1'b0;
    bus.dvld = 1'b0;
    bus.ena = 1'b0;
    bus.i_b = '0;
    bus.rnd = '0;
    set_cur(1'b0, 1'b0);

    repeat (2) apply(rnd_ib(), 1'b1, 1'b1, 0);
    rst_n = 1'b1;

    apply({32'hFFFFFFFF, 32'h0F0F0F0F, 32'h12345678},
          1'b1, 1'b1, 0);
    w = $urandom;
    apply({32'h0, w, w}, 1'b1, 1'b1, 0);
    apply({32'h0, 32'h0, 32'hFFFFFFFF}, 1'b1, 1'b1, 2);
    apply({32'h0, 32'h0, 32'h0}, 1'b1, 1'b1, 0);
    repeat (20) apply(rnd_ib(), 1'b1, 1'b1, 0);

    repeat (5) apply(rnd_ib(), 1'b1, 1'b0, 0);
    repeat (30) apply(rnd_ib(), 1'b1, 1'b1, 0);

    repeat (100) apply(rnd_ib(), 1'b1, 1'b1, 1);

    rst_n = 1'b0;
    apply(rnd_ib(), 1'b1, 1'b1, 0);
    rst_n = 1'b1;
    repeat (20) apply(rnd_ib(), 1'b1, 1'b1, 0);

    for (int c = 0; c < 10000; c++)
      apply(rnd_ib(), $urandom_range(0, 3) != 0,
            $urandom_range(0, 15) != 0, 0);

    repeat (L + 3) apply(rnd_ib(), 1'b0, 1'b1, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end
endmodule
